// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch unit: opcodes, FSM encoding and address-field widths.
package fetch_unit_pkg;

    localparam int OFFSET_W = 2;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DRAIN  = 2'd2
    } fetch_state_t;

    function automatic int word_idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int line_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
        return addr_w - OFFSET_W - $clog2(num_lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Branch history table: 2-bit saturating counters, combinational predict read, clocked update.
module bht
    import fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [$clog2(ENTRIES)-1:0] pred_idx,
    output logic [1:0]                 pred_ctr,
    input  logic                       upd_en,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx,
    input  logic                       upd_taken
);

    logic [1:0] ctr [ENTRIES];

    // Read is combinational, so a same-cycle update is not yet visible to the prediction.
    assign pred_ctr = ctr[pred_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'd1;
            end
        end else if (en && upd_en) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != 2'd3) ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
            end else begin
                if (ctr[upd_idx] != 2'd0) ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: direct-mapped I-cache with word-by-word refill and BHT/JAL next-pc prediction.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int NUM_LINES   = 16,
    parameter int LINE_WORDS  = 16,
    parameter int BHT_ENTRIES = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall,
    input  logic              rollback,
    input  logic [ADDR_W-1:0] rollback_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_pred_taken,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int WI = word_idx_w(LINE_WORDS);
    localparam int LI = line_idx_w(NUM_LINES);
    localparam int TW = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
    localparam int BI = $clog2(BHT_ENTRIES);

    fetch_state_t state, next_state;

    logic [ADDR_W-1:0]    pc;
    logic [WI-1:0]        word_cnt;
    logic [NUM_LINES-1:0] line_valid;
    logic [TW-1:0]        tags  [NUM_LINES];
    logic [31:0]          lines [NUM_LINES*LINE_WORDS];

    logic [LI-1:0] line_idx;
    logic [WI-1:0] word_idx;
    logic [TW-1:0] pc_tag;
    logic          hit;
    logic [31:0]   inst;

    assign line_idx = pc[OFFSET_W+WI +: LI];
    assign word_idx = pc[OFFSET_W +: WI];
    assign pc_tag   = pc[ADDR_W-1 -: TW];
    assign hit      = line_valid[line_idx] && (tags[line_idx] == pc_tag);
    assign inst     = lines[{line_idx, word_idx}];

    logic [1:0] bht_ctr;

    bht #(
        .ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .pred_idx (pc[BI+1:2]),
        .pred_ctr (bht_ctr),
        .upd_en   (upd_valid),
        .upd_idx  (upd_pc[BI+1:2]),
        .upd_taken(upd_taken)
    );

    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[ADDR_W-1:BI+2], upd_pc[1:0]};

    logic [ADDR_W-1:0] b_imm, j_imm, pred_pc;
    logic              pred_taken;

    assign b_imm = {{(ADDR_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm = {{(ADDR_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // JALR and everything else fall through to pc+4.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc + ADDR_W'(4);
        if (inst[6:0] == OPC_BRANCH && bht_ctr >= 2'd2) begin
            pred_taken = 1'b1;
            pred_pc    = pc + b_imm;
        end else if (inst[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            pred_pc    = pc + j_imm;
        end
    end

    logic start_refill, issue, data_we, set_valid, fetch_fire;

    always_comb begin
        next_state   = state;
        start_refill = 1'b0;
        issue        = 1'b0;
        data_we      = 1'b0;
        set_valid    = 1'b0;
        fetch_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (!rollback) begin
                    if (!hit) begin
                        next_state   = REFILL;
                        start_refill = 1'b1;
                    end else if (!stall) begin
                        fetch_fire = 1'b1;
                    end
                end
            end
            REFILL: begin
                // A redirect abandons the refill; the line was invalidated on entry and stays so.
                if (rollback) begin
                    if (mem_req_valid && !mem_resp_valid) next_state = DRAIN;
                    else                                  next_state = IDLE;
                end else if (mem_req_valid) begin
                    if (mem_resp_valid) begin
                        data_we = 1'b1;
                        if (word_cnt == '1) begin
                            set_valid  = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else if (rdy) state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc             <= '0;
            word_cnt       <= '0;
            line_valid     <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            out_valid      <= 1'b0;
            out_inst       <= '0;
            out_pc         <= '0;
            out_pred_taken <= 1'b0;
        end else if (rdy) begin
            out_valid     <= fetch_fire;
            mem_req_valid <= issue | (mem_req_valid & ~mem_resp_valid);
            if (rollback) begin
                pc <= rollback_pc;
            end else if (fetch_fire) begin
                pc <= pred_pc;
            end
            if (fetch_fire) begin
                out_inst       <= inst;
                out_pc         <= pc;
                out_pred_taken <= pred_taken;
            end
            if (issue) begin
                mem_req_addr <= {pc[ADDR_W-1:OFFSET_W+WI], word_cnt, 2'b00};
            end
            if (start_refill) begin
                word_cnt             <= '0;
                line_valid[line_idx] <= 1'b0;
            end else if (data_we) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (set_valid) begin
                line_valid[line_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (start_refill) tags[line_idx] <= pc_tag;
            if (data_we) lines[{line_idx, word_cnt}] <= mem_resp_data;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NUM_LINES, 16, number of direct-mapped I-cache lines (power of 2, >=2).
REQ-002 Parameter LINE_WORDS, 16, 32-bit words per line (power of 2, >=2).
REQ-003 Parameter BHT_ENTRIES, 256, number of 2-bit branch history counters (power of 2).
REQ-004 Parameter ADDR_W, 32, address width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 rdy  in  1  global enable; when 0, all state holds.
REQ-009 stall  in  1  OR of rs_full, rob_full and lsb_full; blocks issue.
REQ-010 rollback  in  1  mispredict redirect strobe.
REQ-011 rollback_pc  in  ADDR_W  redirect target.
REQ-012 upd_valid / upd_pc / upd_taken  in  1/ADDR_W/1  resolved-branch update from the ROB.
REQ-013 out_valid / out_inst / out_pc / out_pred_taken  out  1/32/ADDR_W/1  instruction to the decoder.
REQ-014 mem_req_valid / mem_req_addr  out  1/ADDR_W  word read request.
REQ-015 mem_resp_valid / mem_resp_data  in  1/32  read response.

Function
REQ-016 Address split: offset[1:0], word index log2(LINE_WORDS), line index log2(NUM_LINES), tag = remaining upper bits; BHT index = pc[log2(BHT_ENTRIES)+1:2].
REQ-017 The FSM SHALL have states IDLE, REFILL and DRAIN.
REQ-018 IDLE: on a hit with stall=0, register out_inst and out_pc = pc, assert out_valid for exactly one cycle, and update pc to the predicted next pc.
REQ-019 IDLE hit with stall=1: out_valid=0 and pc holds.
REQ-020 IDLE miss: go to REFILL, clear the line's valid bit and write the tag.
REQ-021 REFILL: fetch words 0..LINE_WORDS-1 of the line in order, one request outstanding at a time; mem_req_valid and mem_req_addr hold until mem_resp_valid; each response writes its word and advances the word counter.
REQ-022 After the last word, set the line valid and return to IDLE; the hit is serviced on the following cycle.
REQ-023 Prediction: B-type (opcode 1100011) with counter >=2 -> pc + B-imm and out_pred_taken=1; JAL (1101111) -> pc + J-imm and out_pred_taken=1; otherwise pc+4 and out_pred_taken=0. JALR is predicted pc+4.
REQ-024 BHT update on upd_valid: 2-bit saturating counter, increment on taken and decrement on not-taken, saturating at 3 and 0; counters reset to 1.
REQ-025 An update and a prediction to the same BHT index in the same cycle: the prediction uses the pre-update value.
REQ-026 Rollback has priority over every other event: pc <= rollback_pc and out_valid <= 0 next cycle.
REQ-027 Rollback in REFILL with no request outstanding: the line stays invalid and the FSM goes to IDLE.
REQ-028 Rollback in REFILL with a request outstanding: the FSM goes to DRAIN, waits for mem_resp_valid, discards the data, then goes to IDLE.
REQ-029 Rollback in REFILL: the line stays invalid in all cases.
REQ-030 rdy=0 freezes the FSM, pc, counters and outputs; a mem_resp_valid arriving while rdy=0 is not supported.
REQ-031 pc and line-address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-032 Reset SHALL set: pc=0, state=IDLE, out_valid=0, out_inst=0, out_pc=0, out_pred_taken=0, mem_req_valid=0, mem_req_addr=0, all line valid bits=0, all BHT counters=1.
REQ-033 Reset mid-REFILL SHALL abandon the refill; any memory response after reset is ignored.

Structure
REQ-034 A shared constants package SHALL hold the opcodes, the FSM state encodings, and the tag/index/offset width functions.
REQ-035 The BHT SHALL be a sub-module, bht, with predict-index read and update ports.

Verification
REQ-036 Cold fetch at pc=0 -> 16 memory requests to 0x00..0x3C, then out_valid with out_pc=0 on the cycle after the last response.
REQ-037 A line with 16 NOPs (0x00000013) after refill, stall=0 -> out_valid every cycle with out_pc 0,4,...,0x3C, no memory requests.
REQ-038 BEQ at 0x10 with offset +0x20: three upd_taken=1 updates -> next fetch has out_pred_taken=1 and next out_pc=0x30; two not-taken updates -> pc+4.
REQ-039 Rollback to 0x100 while the 5th refill request is outstanding -> DRAIN, response discarded, line invalid, next request address 0x100.
REQ-040 stall=1 for 3 cycles during a hit -> out_valid=0 and pc constant; released -> the same out_pc is issued.
REQ-041 Same-cycle rollback and hit -> no out_valid, pc=rollback_pc.
